crop_filter: RTL and testbench

- Upstream neighbour of the normalisation reader; sits between the camera pixel stream and the frame FIFO that the reader drains.
- Per ap_start, waits for start-of-frame, forwards only pixels inside a programmable ROI, and tracks the ROI maximum pixel value.
- Pulses ap_done once the last ROI pixel has left its output register. ap_done is the signal the reader consumes as its crop-filter-done input. roi_max feeds the reader's normalisation denominator.

---
 rtl/crop_filter_pkg.sv | 19 +
 rtl/crop_filter_if.sv | 21 ++
 rtl/crop_filter_roi_coord_counter.sv | 61 ++++++
 rtl/crop_filter.sv | 184 ++++++++++++++++++
 tb/tb_crop_filter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crop_filter_pkg.sv
// crop_pkg: shared types and default widths for the crop filter slice.
//   state_t   : controller states (IDLE, WAIT_SOF, SCAN, DONE)
//   coord_t   : column/row coordinate at the default coordinate width
//   *_DEF     : default parameter values used by the modules and interface
package crop_pkg;

  localparam int PIXEL_BIT_WIDTH_DEF = 10;
  localparam int COORD_WIDTH_DEF     = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    SCAN     = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef logic [COORD_WIDTH_DEF-1:0] coord_t;

endpackage

// File: rtl/crop_filter_if.sv
// crop_filter_if: AXI4-Stream style pixel bus used on both sides of the
// crop filter.
//   tvalid/tready : handshake, a beat transfers when both are high
//   tdata         : pixel value (DATA_W bits)
//   tuser         : start of frame on the first pixel
//   tlast         : end of line (input side) / last ROI pixel (output side)
// Modports: master drives the beat, slave drives tready.
interface crop_filter_if #(
  parameter int DATA_W = crop_pkg::PIXEL_BIT_WIDTH_DEF
);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tuser;
  logic              tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);

endinterface

// File: rtl/crop_filter_roi_coord_counter.sv
// roi_coord_counter: tracks the (x,y) position of the next accepted pixel in
// the frame and classifies it against the latched ROI.
//   clk, srst    : clock and synchronous active-high reset
//   clear        : force position back to (0,0)
//   step         : an accepted pixel is being consumed at the current (x,y)
//   line_end     : the consumed pixel carries end-of-line
//   x0, y0, w, h : latched ROI origin and size
//   in_roi       : current (x,y) lies inside the ROI
//   is_last_roi  : current (x,y) is the bottom-right pixel of the ROI
module roi_coord_counter
  import crop_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   clear,
  input  logic                   step,
  input  logic                   line_end,
  input  logic [COORD_WIDTH-1:0] x0,
  input  logic [COORD_WIDTH-1:0] y0,
  input  logic [COORD_WIDTH-1:0] w,
  input  logic [COORD_WIDTH-1:0] h,
  output logic                   in_roi,
  output logic                   is_last_roi
);

  logic [COORD_WIDTH-1:0] x;
  logic [COORD_WIDTH-1:0] y;

  // One extra bit so x0+w and y0+h never wrap around the coordinate range.
  logic [COORD_WIDTH:0] x_ext;
  logic [COORD_WIDTH:0] y_ext;
  logic [COORD_WIDTH:0] x_end;
  logic [COORD_WIDTH:0] y_end;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (line_end) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_comb begin
    x_ext       = {1'b0, x};
    y_ext       = {1'b0, y};
    x_end       = {1'b0, x0} + {1'b0, w};
    y_end       = {1'b0, y0} + {1'b0, h};
    in_roi      = (x_ext >= {1'b0, x0}) && (x_ext < x_end) &&
                  (y_ext >= {1'b0, y0}) && (y_ext < y_end);
    is_last_roi = in_roi && (x_ext == x_end - 1'b1) && (y_ext == y_end - 1'b1);
  end

endmodule

// File: rtl/crop_filter.sv
// crop_filter: per ap_start, waits for start-of-frame on the camera stream,
// forwards only the pixels inside a programmable ROI and tracks the maximum
// forwarded value. ap_done pulses once the last ROI pixel has left the
// output register.
//   clk, srst                    : clock, synchronous active-high reset
//   ap_start                     : start pulse, honoured only while idle
//   ap_done                      : one-cycle completion pulse
//   ap_idle                      : high while idle
//   roi_x0/roi_y0/roi_w/roi_h    : ROI origin and size, latched on start
//   roi_max                      : maximum forwarded pixel of the run
//   roi_err                      : run aborted by an early start-of-frame
//   s_axis (slave)               : camera pixel stream in
//   m_axis (master)              : cropped pixel stream out (tlast = last ROI pixel)
module crop_filter
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = PIXEL_BIT_WIDTH_DEF,
  parameter int COORD_WIDTH     = COORD_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  input  logic [COORD_WIDTH-1:0]     roi_x0,
  input  logic [COORD_WIDTH-1:0]     roi_y0,
  input  logic [COORD_WIDTH-1:0]     roi_w,
  input  logic [COORD_WIDTH-1:0]     roi_h,
  output logic [PIXEL_BIT_WIDTH-1:0] roi_max,
  output logic                       roi_err,
  crop_filter_if.slave               s_axis,
  crop_filter_if.master              m_axis
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_WAIT_SOF = WAIT_SOF;
  localparam logic [1:0] ST_SCAN     = SCAN;
  localparam logic [1:0] ST_DONE     = DONE;

  function automatic logic [PIXEL_BIT_WIDTH-1:0] pix_max(
    input logic [PIXEL_BIT_WIDTH-1:0] a,
    input logic [PIXEL_BIT_WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  logic [1:0]                 state;
  logic [COORD_WIDTH-1:0]     x0_r;
  logic [COORD_WIDTH-1:0]     y0_r;
  logic [COORD_WIDTH-1:0]     w_r;
  logic [COORD_WIDTH-1:0]     h_r;
  logic                       done_r;

  logic                       vld_p1;
  logic [PIXEL_BIT_WIDTH-1:0] tdata_p1;
  logic                       tlast_p1;

  logic s_ready;
  logic accept;
  logic start_acc;
  logic step;
  logic abort;
  logic load;
  logic finish;
  logic cnt_clear;
  logic in_roi;
  logic is_last_roi;

  always_comb begin
    // Outside SCAN every beat is either consumed as SOF or discarded, so the
    // camera never sees backpressure there.
    s_ready   = (state == ST_SCAN) ? (!vld_p1 || m_axis.tready) : 1'b1;
    accept    = s_axis.tvalid && s_ready;
    start_acc = (state == ST_IDLE) && ap_start;
    cnt_clear = (state == ST_IDLE);
    step      = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_WAIT_SOF: step = accept && s_axis.tuser;
      ST_SCAN: begin
        // A fresh SOF before the ROI completed ends the run; that beat is dropped.
        abort = accept && s_axis.tuser;
        step  = accept && !s_axis.tuser;
      end
      default: ;
    endcase
    load   = step && in_roi;
    finish = load && is_last_roi;
  end

  roi_coord_counter #(
    .COORD_WIDTH (COORD_WIDTH)
  ) u_coord (
    .clk         (clk),
    .srst        (srst),
    .clear       (cnt_clear),
    .step        (step),
    .line_end    (s_axis.tlast),
    .x0          (x0_r),
    .y0          (y0_r),
    .w           (w_r),
    .h           (h_r),
    .in_roi      (in_roi),
    .is_last_roi (is_last_roi)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state   <= ST_IDLE;
      x0_r    <= '0;
      y0_r    <= '0;
      w_r     <= '0;
      h_r     <= '0;
      roi_err <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            x0_r    <= roi_x0;
            y0_r    <= roi_y0;
            w_r     <= roi_w;
            h_r     <= roi_h;
            roi_err <= 1'b0;
            // An empty ROI has nothing to forward; finish straight away.
            state   <= ((roi_w == '0) || (roi_h == '0)) ? ST_DONE : ST_WAIT_SOF;
          end
        end
        ST_WAIT_SOF: begin
          if (step) state <= finish ? ST_DONE : ST_SCAN;
        end
        ST_SCAN: begin
          if (abort) begin
            roi_err <= 1'b1;
            state   <= ST_DONE;
          end else if (finish) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Completion is only reported once the output register has drained.
          if (!vld_p1) begin
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst || start_acc) begin
      roi_max <= '0;
    end else if (load) begin
      roi_max <= pix_max(roi_max, s_axis.tdata);
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (srst) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tlast_p1 <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= s_axis.tdata;
      tlast_p1 <= is_last_roi;
    end else if (m_axis.tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = vld_p1;
  assign m_axis.tdata  = tdata_p1;
  assign m_axis.tlast  = tlast_p1;
  assign m_axis.tuser  = 1'b0;
  assign ap_done       = done_r;
  assign ap_idle       = (state == ST_IDLE);

endmodule

// File: tb/tb_crop_filter.sv
`timescale 1ns/1ps
module tb_crop_filter;

  localparam int PW = 10;
  localparam int CW = 12;

  logic          clk;
  logic          srst;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          roi_err;
  logic [CW-1:0] roi_x0, roi_y0, roi_w, roi_h;
  logic [PW-1:0] roi_max;

  crop_filter_if #(.DATA_W(PW)) s_axis ();
  crop_filter_if #(.DATA_W(PW)) m_axis ();

  crop_filter #(
    .PIXEL_BIT_WIDTH (PW),
    .COORD_WIDTH     (CW)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .ap_idle  (ap_idle),
    .roi_x0   (roi_x0),
    .roi_y0   (roi_y0),
    .roi_w    (roi_w),
    .roi_h    (roi_h),
    .roi_max  (roi_max),
    .roi_err  (roi_err),
    .s_axis   (s_axis),
    .m_axis   (m_axis)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [PW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  int    frm [16][16];
  int    exp_d[$];
  int    exp_l[$];
  int    exp_max;
  bit    exp_err;
  bit    exp_complete;
  beat_t beats[$];

  // Builds the frame, the beat list fed to the DUT and the expected output.
  task automatic build(input int x0, input int y0, input int w, input int h,
                       input int fw, input int fh, input int junk, input bit pixrand);
    beat_t b;
    bit    empty;
    exp_d.delete();
    exp_l.delete();
    beats.delete();
    exp_max = 0;
    for (int y = 0; y < fh; y++)
      for (int x = 0; x < fw; x++)
        frm[y][x] = pixrand ? int'($urandom_range(0, 1023)) : y * fw + x;
    empty        = (w == 0) || (h == 0);
    exp_complete = empty || ((x0 + w <= fw) && (y0 + h <= fh));
    exp_err      = !exp_complete;
    if (!empty)
      for (int y = 0; y < fh; y++)
        for (int x = 0; x < fw; x++)
          if (x >= x0 && x < x0 + w && y >= y0 && y < y0 + h) begin
            exp_d.push_back(frm[y][x]);
            exp_l.push_back((x == x0 + w - 1 && y == y0 + h - 1) ? 1 : 0);
            if (frm[y][x] > exp_max) exp_max = frm[y][x];
          end
    for (int j = 0; j < junk; j++) begin
      b.d = PW'($urandom_range(0, 1023));
      b.u = 1'b0;
      b.l = 1'($urandom_range(0, 1));
      beats.push_back(b);
    end
    for (int y = 0; y < fh; y++)
      for (int x = 0; x < fw; x++) begin
        b.d = PW'(frm[y][x]);
        b.u = (x == 0 && y == 0);
        b.l = (x == fw - 1);
        beats.push_back(b);
      end
    if (exp_err) begin
      b.d = PW'($urandom_range(0, 1023));
      b.u = 1'b1;
      b.l = 1'b0;
      beats.push_back(b);
    end
  endtask

  // ---------------- downstream ready generator ----------------
  int rdy_mode = 0;
  bit tog = 1'b0;

  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_axis.tready = 1'b1;
        1: begin tog = ~tog; m_axis.tready = tog; end
        2: m_axis.tready = 1'($urandom_range(0, 1));
        default: m_axis.tready = 1'b0;
      endcase
    end
  end

  // ---------------- output compare process ----------------
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            out_cnt = 0;
  int            tlast_cnt = 0;
  int            last_xfer_cyc = -1;
  bit            stall_prev = 1'b0;
  logic [PW:0]   prev_beat;

  initial forever begin
    @(negedge clk);
    if (srst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(m_axis.tvalid), 32'd1);
        chk("hold_beat", 32'({m_axis.tlast, m_axis.tdata}), 32'(prev_beat));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_beat", 32'(m_axis.tdata), 32'hFFFF_FFFF);
        end else begin
          chk("tdata", 32'(m_axis.tdata), 32'(exp_d.pop_front()));
          chk("tlast", 32'(m_axis.tlast), 32'(exp_l.pop_front()));
        end
        out_cnt++;
        if (m_axis.tlast) tlast_cnt++;
        last_xfer_cyc = cyc;
      end
      stall_prev = m_axis.tvalid && !m_axis.tready;
      prev_beat  = {m_axis.tlast, m_axis.tdata};
      if (ap_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input beat_t b, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = b.d;
    s_axis.tuser  = b.u;
    s_axis.tlast  = b.l;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_axis.tready) break;
      n++;
      if (n >= 500) break;
    end
    if (n >= 500) chk("beat_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  int start_cyc;

  task automatic start_run(input int x0, input int y0, input int w, input int h);
    roi_x0    = CW'(x0);
    roi_y0    = CW'(y0);
    roi_w     = CW'(w);
    roi_h     = CW'(h);
    done_cnt  = 0;
    done_cyc  = -1;
    out_cnt   = 0;
    tlast_cnt = 0;
    last_xfer_cyc = -1;
    ap_start  = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    ap_start  = 1'b0;
  endtask

  task automatic run_case(input string tag, input int x0, input int y0, input int w, input int h,
                          input int fw, input int fh, input int junk, input bit pixrand,
                          input bit gaps, input int rmode);
    int n;
    build(x0, y0, w, h, fw, fh, junk, pixrand);
    rdy_mode = rmode;
    start_run(x0, y0, w, h);
    foreach (beats[i]) send_beat(beats[i], gaps);
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (6) begin @(posedge clk); #1; end
    chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, " leftover"}, 32'(exp_d.size()), 32'd0);
    chk({tag, " roi_max"}, 32'(roi_max), 32'(exp_max));
    chk({tag, " roi_err"}, 32'(roi_err), 32'(exp_err));
    chk({tag, " idle"}, 32'(ap_idle), 32'd1);
    if (exp_complete && out_cnt > 0)
      chk({tag, " done_latency"}, 32'(done_cyc - last_xfer_cyc), 32'd2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    srst          = 1'b1;
    ap_start      = 1'b0;
    roi_x0        = '0;
    roi_y0        = '0;
    roi_w         = '0;
    roi_h         = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    chk("rst ap_idle", 32'(ap_idle), 32'd1);
    chk("rst ap_done", 32'(ap_done), 32'd0);
    chk("rst s_tready", 32'(s_axis.tready), 32'd1);
    chk("rst m_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("rst m_tdata", 32'(m_axis.tdata), 32'd0);
    chk("rst m_tlast", 32'(m_axis.tlast), 32'd0);
    chk("rst roi_max", 32'(roi_max), 32'd0);
    chk("rst roi_err", 32'(roi_err), 32'd0);
    @(posedge clk);
    #1;

    // ap_start together with reset must be ignored
    roi_w = '0; roi_h = CW'(1);
    done_cnt = 0;
    srst = 1'b1; ap_start = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0; ap_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("start_in_reset done", 32'(done_cnt), 32'd0);
    chk("start_in_reset idle", 32'(ap_idle), 32'd1);

    // model pin: 2x2 ROI at (1,1) of a 4x3 index frame
    build(1, 1, 2, 2, 4, 3, 0, 1'b0);
    chk("model n", 32'(exp_d.size()), 32'd4);
    chk("model d0", 32'(exp_d[0]), 32'd5);
    chk("model d1", 32'(exp_d[1]), 32'd6);
    chk("model d2", 32'(exp_d[2]), 32'd9);
    chk("model d3", 32'(exp_d[3]), 32'd10);
    chk("model last", 32'(exp_l[3] * 8 + exp_l[2] * 4 + exp_l[1] * 2 + exp_l[0]), 32'd8);

    run_case("s1", 1, 1, 2, 2, 4, 3, 0, 1'b0, 1'b0, 0);
    chk("s1 roi_max literal", 32'(roi_max), 32'd10);
    chk("s1 beats", 32'(out_cnt), 32'd4);
    chk("s1 tlast count", 32'(tlast_cnt), 32'd1);

    run_case("s2 toggle", 1, 1, 2, 2, 4, 3, 0, 1'b0, 1'b0, 1);
    chk("s2 beats", 32'(out_cnt), 32'd4);

    run_case("s3 presof", 1, 1, 2, 2, 4, 3, 3, 1'b0, 1'b0, 0);
    chk("s3 beats", 32'(out_cnt), 32'd4);

    run_case("s4 abort", 0, 0, 4, 4, 4, 3, 0, 1'b0, 1'b0, 0);
    chk("s4 roi_err literal", 32'(roi_err), 32'd1);
    chk("s4 beats", 32'(out_cnt), 32'd12);
    chk("s4 tlast count", 32'(tlast_cnt), 32'd0);

    run_case("s5 empty", 2, 1, 0, 3, 4, 3, 0, 1'b0, 1'b0, 0);
    chk("s5 done_latency", 32'(done_cyc - start_cyc), 32'd2);
    chk("s5 beats", 32'(out_cnt), 32'd0);
    chk("s5 roi_max literal", 32'(roi_max), 32'd0);

    // reset while a forwarded pixel is stalled in the output register
    build(1, 1, 2, 2, 4, 3, 0, 1'b0);
    rdy_mode = 3;
    @(posedge clk); #1;
    start_run(1, 1, 2, 2);
    for (int i = 0; i < 6; i++) send_beat(beats[i], 1'b0);
    @(negedge clk);
    chk("s6 pre_reset valid", 32'(m_axis.tvalid), 32'd1);
    @(posedge clk); #1;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    chk("s6 post_reset valid", 32'(m_axis.tvalid), 32'd0);
    chk("s6 post_reset idle", 32'(ap_idle), 32'd1);
    exp_d.delete();
    exp_l.delete();
    rdy_mode = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("s6 no done", 32'(done_cnt), 32'd0);
    run_case("s6 rerun", 1, 1, 2, 2, 4, 3, 0, 1'b0, 1'b0, 0);
    chk("s6 rerun roi_max literal", 32'(roi_max), 32'd10);

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      int fw, fh, x0, y0, w, h;
      fw = $urandom_range(1, 8);
      fh = $urandom_range(1, 6);
      if ($urandom_range(0, 3) != 0) begin
        x0 = $urandom_range(0, fw - 1);
        y0 = $urandom_range(0, fh - 1);
        w  = $urandom_range(1, fw - x0);
        h  = $urandom_range(1, fh - y0);
      end else begin
        x0 = $urandom_range(0, fw);
        y0 = $urandom_range(0, fh);
        w  = $urandom_range(1, fw + 1);
        h  = $urandom_range(1, fh + 1);
      end
      run_case($sformatf("rand%0d", r), x0, y0, w, h, fw, fh,
               $urandom_range(0, 3), 1'b1, 1'b1, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
